// File: rtl/crc8_share_ctrl.sv
// Round-robin front end that time-shares one serial CRC-8 engine between NREQ requesters.
// One job at a time: start pulse, 32 data bits MSB first, then 8 serial result bits.
module crc8_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        crc_result,
  output logic              err,
  output logic              busy,
  output logic              eng_start,
  output logic              eng_data,
  output logic              eng_data_valid,
  input  logic              eng_crc_out,
  input  logic              eng_crc_valid
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(NREQ);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    FEED    = 3'd2,
    WAIT    = 3'd3,
    COLLECT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  grant;
  logic [DATA_W-1:0] word_sh;
  logic [4:0]        bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        crc_sh;
  logic [3:0]        crc_cnt;

  logic              gnt_found;
  logic [IDX_W-1:0]  gnt_idx;
  int                cand;

  // A short result is left-justified so the first captured bit stays the MSB.
  function automatic logic [7:0] align_crc(input logic [7:0] sh, input logic [3:0] n);
    return sh << (4'd8 - n);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  // Outputs are registered one state ahead: they are loaded on the edge that enters the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last           <= IDX_W'(NREQ - 1);
      grant          <= '0;
      word_sh        <= '0;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      crc_sh         <= '0;
      crc_cnt        <= '0;
      done           <= '0;
      crc_result     <= '0;
      err            <= 1'b0;
      busy           <= 1'b0;
      eng_start      <= 1'b0;
      eng_data       <= 1'b0;
      eng_data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            grant     <= gnt_idx;
            last      <= gnt_idx;
            word_sh   <= req_data[gnt_idx*DATA_W +: DATA_W];
            bit_cnt   <= '0;
            to_cnt    <= '0;
            crc_sh    <= '0;
            crc_cnt   <= '0;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          eng_start      <= 1'b0;
          eng_data_valid <= 1'b1;
          eng_data       <= word_sh[DATA_W-1];
          word_sh        <= {word_sh[DATA_W-2:0], 1'b0};
          state          <= FEED;
        end
        FEED: begin
          if (bit_cnt == 5'd31) begin
            eng_data_valid <= 1'b0;
            eng_data       <= 1'b0;
            state          <= WAIT;
          end else begin
            bit_cnt  <= bit_cnt + 5'd1;
            eng_data <= word_sh[DATA_W-1];
            word_sh  <= {word_sh[DATA_W-2:0], 1'b0};
          end
        end
        WAIT: begin
          if (eng_crc_valid) begin
            crc_sh  <= {crc_sh[6:0], eng_crc_out};
            crc_cnt <= 4'd1;
            state   <= COLLECT;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            done       <= onehot(grant);
            crc_result <= align_crc(crc_sh, crc_cnt);
            err        <= 1'b1;
            state      <= DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        COLLECT: begin
          if (eng_crc_valid) begin
            crc_sh  <= {crc_sh[6:0], eng_crc_out};
            crc_cnt <= crc_cnt + 4'd1;
            if (crc_cnt == 4'd7) begin
              done       <= onehot(grant);
              crc_result <= {crc_sh[6:0], eng_crc_out};
              err        <= 1'b0;
              state      <= DONE;
            end
          end else begin
            done       <= onehot(grant);
            crc_result <= align_crc(crc_sh, crc_cnt);
            err        <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
